// File: rtl/key_step_gen.sv
// Push-button single-step clock: synchronizer, counter-based debounce FSM, fixed-width StepClk
// pulse, one-cycle Strobe and 16-bit press counter. Optional auto-repeat under `AUTO_REPEAT_EN.
module key_step_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PULSE_CYCLES    = 1000,
  parameter int CNT_W           = 20
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
`endif
) (
  input  logic        CLOCK_50,
  input  logic        Reset,
  input  logic        KeyN,
  output logic        StepClk,
  output logic        Strobe,
  output logic        Pressed,
  output logic [15:0] StepCount
);

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    HELD,
    DB_RELEASE
  } state_e;

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   k;
  state_e                 state_q;
  logic [CNT_W-1:0]       db_cnt_q;
  logic [CNT_W-1:0]       pulse_cnt_q;
  logic                   pressed_q;
  logic                   strobe_q;
  logic                   stepclk_q;
  logic [15:0]            step_count_q;
  logic [15:0]            step_count_d;
  logic                   step_d;
  logic                   rep_fire;

  // NOTE: the chain resets to all-ones so a released key is never seen as a press after reset.
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], KeyN};
  end

  assign k = ~sync_q[SYNC_STAGES-1];

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    step_d = 1'b0;
    case (state_q)
      DB_PRESS: step_d = k && (db_cnt_q == DB_LAST);
      HELD:     step_d = k && rep_fire;
      default:  step_d = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      db_cnt_q  <= '0;
      pressed_q <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      strobe_q <= step_d;
      case (state_q)
        IDLE: begin
          if (k) begin
            state_q  <= DB_PRESS;
            db_cnt_q <= '0;
          end
        end
        DB_PRESS: begin
          if (!k) begin
            state_q <= IDLE;
          end else if (db_cnt_q == DB_LAST) begin
            state_q   <= HELD;
            pressed_q <= 1'b1;
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end
        HELD: begin
          if (!k) begin
            state_q  <= DB_RELEASE;
            db_cnt_q <= '0;
          end
        end
        DB_RELEASE: begin
          if (k) begin
            state_q <= HELD;
          end else if (db_cnt_q == DB_LAST) begin
            state_q   <= IDLE;
            pressed_q <= 1'b0;
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [31:0] DELAY_LAST  = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] PERIOD_LAST = 32'(REPEAT_PERIOD - 1);

  logic [31:0] rep_cnt_q;
  logic        rep_armed_q;

  assign rep_fire = (rep_cnt_q == (rep_armed_q ? PERIOD_LAST : DELAY_LAST));

  // Counts only while settled in HELD; any other cycle, including a bounce, restarts the delay.
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
    end else if (state_q == HELD && k) begin
      if (rep_fire) begin
        rep_cnt_q   <= '0;
        rep_armed_q <= 1'b1;
      end else begin
        rep_cnt_q <= rep_cnt_q + 1'b1;
      end
    end else begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Pulse timer runs independently of the FSM; a new step reloads it without dropping StepClk.
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      stepclk_q   <= 1'b0;
      pulse_cnt_q <= '0;
    end else if (step_d) begin
      stepclk_q   <= 1'b1;
      pulse_cnt_q <= PULSE_LAST;
    end else if (stepclk_q) begin
      if (pulse_cnt_q == '0) stepclk_q   <= 1'b0;
      else                   pulse_cnt_q <= pulse_cnt_q - 1'b1;
    end
  end

  assign step_count_d = step_count_q + 16'(step_d);

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) step_count_q <= '0;
    else       step_count_q <= step_count_d;
  end

  assign StepClk   = stepclk_q;
  assign Strobe    = strobe_q;
  assign Pressed   = pressed_q;
  assign StepCount = step_count_q;

endmodule

// File: tb/tb_key_step_gen.sv
// Self-checking bench for key_step_gen: directed and random key activity compared every cycle
// against an edge-level model (run-length debounce, pulse deadline, press counter).
module tb_key_step_gen;

  localparam int SYNC  = 2;
  localparam int DB    = 4;
  localparam int PULSE = 3;
`ifdef AUTO_REPEAT_EN
  localparam int RDLY  = 10;
  localparam int RPER  = 5;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        keyn;
  logic        step_clk;
  logic        strobe;
  logic        pressed;
  logic [15:0] step_count;

  always #5 clk = ~clk;

  key_step_gen #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DB),
    .PULSE_CYCLES   (PULSE),
    .CNT_W          (8)
`ifdef AUTO_REPEAT_EN
    ,
    .REPEAT_DELAY   (RDLY),
    .REPEAT_PERIOD  (RPER)
`endif
  ) dut (
    .CLOCK_50 (clk),
    .Reset    (rst),
    .KeyN     (keyn),
    .StepClk  (step_clk),
    .Strobe   (strobe),
    .Pressed  (pressed),
    .StepCount(step_count)
  );

  int vectors = 0;
  int miscompares = 0;
  string phase = "init";

  // Reference model state: t is the index of the last clock edge since reset release.
  int          t;
  bit          kn_pipe[$];
  bit          kwin[$];
  bit          level;
  int          hold_start;
  int          last_zero;
  int          pulse_until;
  logic [15:0] count;
  bit          exp_strobe;
  int          first_strobe_t;

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s/%s @edge %0d: observed %h expected %h", phase, tag, t, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("StepClk",   16'(step_clk),  16'(t <= pulse_until));
    check("Strobe",    16'(strobe),    16'(exp_strobe));
    check("Pressed",   16'(pressed),   16'(level));
    check("StepCount", step_count,     count);
  endtask

  task automatic model_reset();
    t = 0;
    kn_pipe.delete();
    for (int i = 0; i < SYNC; i++) kn_pipe.push_back(1'b1);
    kwin.delete();
    level       = 1'b0;
    hold_start  = 0;
    last_zero   = -1;
    pulse_until = -1;
    count       = '0;
    exp_strobe  = 1'b0;
  endtask

  // Debounced level flips once the last DB+1 synchronized samples all disagree with it.
  task automatic model_edge(bit kn);
    bit k;
    bit all1;
    bit all0;
    bit rep;
    t++;
    k = ~kn_pipe.pop_front();
    kn_pipe.push_back(kn);
    kwin.push_back(k);
    if (kwin.size() > DB + 1) void'(kwin.pop_front());
    all1 = (kwin.size() == DB + 1);
    all0 = all1;
    foreach (kwin[i]) begin
      if (kwin[i])  all0 = 1'b0;
      if (!kwin[i]) all1 = 1'b0;
    end
    exp_strobe = 1'b0;
    rep = 1'b0;
    if (!level && all1) begin
      level      = 1'b1;
      hold_start = t;
      exp_strobe = 1'b1;
    end else if (level && all0) begin
      level = 1'b0;
    end else if (level) begin
      if (!k) last_zero = t;
`ifdef AUTO_REPEAT_EN
      begin
        int s;
        s = (hold_start > last_zero + 1) ? hold_start : last_zero + 1;
        if (t - s >= RDLY && ((t - s - RDLY) % RPER) == 0) rep = 1'b1;
      end
`endif
    end
    if (rep) exp_strobe = 1'b1;
    if (exp_strobe) begin
      count       = count + 16'd1;
      pulse_until = t + PULSE - 1;
    end
  endtask

  task automatic tick(bit kn);
    keyn = kn;
    @(posedge clk);
    model_edge(kn);
    #1;
    if (strobe === 1'b1 && first_strobe_t < 0) first_strobe_t = t;
    check_outputs();
  endtask

  task automatic ticks(bit kn, int n);
    for (int i = 0; i < n; i++) tick(kn);
  endtask

  // Asserts reset between clock edges, so outputs must clear without waiting for a clock.
  task automatic do_reset(int hold);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_outputs();
    end
    rst = 1'b0;
  endtask

  task automatic bouncy_press(int bounces, int hold);
    for (int b = 0; b < bounces; b++) begin
      ticks(1'b0, int'($urandom_range(1, 3)));
      ticks(1'b1, int'($urandom_range(1, 3)));
    end
    ticks(1'b0, hold);
    for (int b = 0; b < bounces; b++) begin
      ticks(1'b1, int'($urandom_range(1, 3)));
      ticks(1'b0, int'($urandom_range(1, 3)));
    end
    ticks(1'b1, SYNC + DB + 3);
  endtask

  initial begin
    rst  = 1'b1;
    keyn = 1'b1;
    first_strobe_t = -1;
    model_reset();
    @(posedge clk);
    #1;
    phase = "reset";
    do_reset(2);

    phase = "idle";
    ticks(1'b1, 9);

    phase = "clean_press";
    first_strobe_t = -1;
    begin
      int press_edge;
      press_edge = t + 1;
      ticks(1'b0, 20);
      check("Latency", 16'(first_strobe_t), 16'(press_edge + SYNC + DB));
    end
    ticks(1'b1, 12);

    phase = "bounce_reject";
    for (int i = 0; i < 5; i++) begin
      ticks(1'b0, 2);
      ticks(1'b1, 2);
    end
    ticks(1'b1, 10);

    phase = "long_hold";
    ticks(1'b0, 100);
    ticks(1'b1, 1); ticks(1'b0, 1);
    ticks(1'b1, 1); ticks(1'b0, 1);
    ticks(1'b1, 12);

    phase = "mid_pulse_reset";
    first_strobe_t = -1;
    ticks(1'b0, SYNC + DB + 2);
    keyn = 1'b1;
    do_reset(3);
    ticks(1'b1, 8);

    phase = "random";
    for (int i = 0; i < 40; i++) begin
      bouncy_press(int'($urandom_range(0, 3)), int'($urandom_range(1, 15)));
      if ($urandom_range(0, 9) == 0) do_reset(int'($urandom_range(1, 3)));
    end

    phase = "wrap";
    ticks(1'b1, 4);
    force dut.step_count_d = 16'hFFFF;
    keyn = 1'b1;
    @(posedge clk);
    model_edge(1'b1);
    count = 16'hFFFF;
    #1;
    check_outputs();
    release dut.step_count_d;
    ticks(1'b1, 2);
    ticks(1'b0, 12);
    check("WrapCount", step_count, 16'h0000);
    ticks(1'b1, 12);

`ifdef AUTO_REPEAT_EN
    phase = "auto_repeat";
    begin
      int start;
      start = count;
      ticks(1'b0, SYNC + DB + 1 + 30);
      check("RepeatSteps", step_count - 16'(start), 16'd6);
      ticks(1'b1, 12);
      check("RepeatStop", step_count - 16'(start), 16'd6);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
